// File: rtl/hamming_enc_engine.sv
// hamming_enc_engine: reads NUM_MSG 11-bit messages from byte memory,
// encodes each as a SECDED (16,11) Hamming codeword, writes it back.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        run request (honoured only in IDLE or DONE)
//   done         high while the engine sits in DONE
//   mem_addr     byte address (reads and writes)
//   mem_rd_data  combinational read data for mem_addr
//   mem_wr_en    write strobe, memory captures on rising clk
//   mem_wr_data  write data
module hamming_enc_engine #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    localparam logic [7:0] LP_SRC  = 8'(SRC_BASE);
    localparam logic [7:0] LP_DST  = 8'(DST_BASE);
    localparam logic [3:0] LP_LAST = 4'(NUM_MSG - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_idx;
    logic [7:0]  r_lo;
    logic [2:0]  r_hi;

    logic        w_ld_lo;
    logic        w_ld_hi;
    logic        w_idx_clr;
    logic        w_idx_inc;

    logic [7:0]  w_off;
    logic [11:1] w_d;
    logic        w_p8;
    logic        w_p4;
    logic        w_p2;
    logic        w_p1;
    logic        w_p0;
    logic [15:0] w_cw;

    // Byte offset of message/codeword i; wraps modulo 256 with the base.
    assign w_off = {3'b000, r_idx, 1'b0};

    // Message bits d[11:1] taken straight from the latched bytes.
    assign w_d = {r_hi, r_lo};

    assign w_p8 = ^w_d[11:5];
    assign w_p4 = (^w_d[11:8]) ^ (^w_d[4:2]);
    assign w_p2 = w_d[11] ^ w_d[10] ^ w_d[7] ^ w_d[6]
                ^ w_d[4] ^ w_d[3] ^ w_d[1];
    assign w_p1 = w_d[11] ^ w_d[9] ^ w_d[7] ^ w_d[5]
                ^ w_d[4] ^ w_d[2] ^ w_d[1];
    // Overall parity covers data and the four Hamming bits (SECDED).
    assign w_p0 = (^w_d) ^ w_p8 ^ w_p4 ^ w_p2 ^ w_p1;

    assign w_cw = {w_d[11:5], w_p8, w_d[4:2], w_p4,
                   w_d[1], w_p2, w_p1, w_p0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= 4'd0;
            r_lo  <= 8'd0;
            r_hi  <= 3'd0;
        end else begin
            if (w_ld_lo) begin
                r_lo <= mem_rd_data;
            end
            if (w_ld_hi) begin
                r_hi <= mem_rd_data[2:0];
            end
            if (w_idx_clr) begin
                r_idx <= 4'd0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    // Outputs decode from r_state only, so an async reset drives them
    // to zero at once without waiting for a clock.
    always_comb begin
        w_next      = r_state;
        done        = 1'b0;
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        w_ld_lo     = 1'b0;
        w_ld_hi     = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next    = S_RD_LO;
                    w_idx_clr = 1'b1;
                end
            end
            S_RD_LO: begin
                mem_addr = LP_SRC + w_off;
                w_ld_lo  = 1'b1;
                w_next   = S_RD_HI;
            end
            S_RD_HI: begin
                mem_addr = LP_SRC + w_off + 8'd1;
                w_ld_hi  = 1'b1;
                w_next   = S_WR_LO;
            end
            S_WR_LO: begin
                mem_addr    = LP_DST + w_off;
                mem_wr_en   = 1'b1;
                mem_wr_data = w_cw[7:0];
                w_next      = S_WR_HI;
            end
            S_WR_HI: begin
                mem_addr    = LP_DST + w_off + 8'd1;
                mem_wr_en   = 1'b1;
                mem_wr_data = w_cw[15:8];
                if (r_idx == LP_LAST) begin
                    w_next = S_DONE;
                end else begin
                    w_idx_inc = 1'b1;
                    w_next    = S_RD_LO;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next    = S_RD_LO;
                    w_idx_clr = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// tb_hamming_enc_engine: directed bench for hamming_enc_engine with a
// byte-memory model, fixed message table and hand-checked codewords.
module tb_hamming_enc_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [0:255];
    logic       tb_ld = 1'b0;
    logic [7:0] tb_ld_addr = 8'd0;
    logic [7:0] tb_ld_data = 8'd0;
    int         wr_cnt = 0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] src_lo [15];
    logic [7:0] src_hi [15];
    logic [7:0] exp_lo [15];
    logic [7:0] exp_hi [15];

    hamming_enc_engine #(
        .NUM_MSG (15),
        .SRC_BASE(0),
        .DST_BASE(30)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_cnt <= wr_cnt + 1;
        end else if (tb_ld) begin
            mem[tb_ld_addr] <= tb_ld_data;
        end
    end

    // Reference encoder written bit by bit from the parity equations.
    function automatic logic [15:0] enc(input logic [7:0] lo,
                                        input logic [7:0] hi);
        logic [11:1] d;
        logic p8, p4, p2, p1, p0;
        d  = {hi[2:0], lo};
        p8 = d[11]^d[10]^d[9]^d[8]^d[7]^d[6]^d[5];
        p4 = d[11]^d[10]^d[9]^d[8]^d[4]^d[3]^d[2];
        p2 = d[11]^d[10]^d[7]^d[6]^d[4]^d[3]^d[1];
        p1 = d[11]^d[9]^d[7]^d[5]^d[4]^d[2]^d[1];
        p0 = d[11]^d[10]^d[9]^d[8]^d[7]^d[6]^d[5]^d[4]^d[3]^d[2]^d[1]
           ^ p8^p4^p2^p1;
        return {d[11], d[10], d[9], d[8], d[7], d[6], d[5], p8,
                d[4], d[3], d[2], p4, d[1], p2, p1, p0};
    endfunction

    task automatic load_byte(input logic [7:0] a, input logic [7:0] v);
        tb_ld      = 1'b1;
        tb_ld_addr = a;
        tb_ld_data = v;
        @(posedge clk);
        #1;
        tb_ld = 1'b0;
    endtask

    task automatic setup_tables();
        logic [15:0] cw;
        src_lo = '{8'h00, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hA5, 8'h3C,
                   8'h5A, 8'hC3, 8'h12, 8'h7E, 8'h81, 8'hF0, 8'h0F,
                   8'h66};
        src_hi = '{8'h00, 8'h07, 8'h00, 8'h04, 8'hF8, 8'h03, 8'h05,
                   8'h02, 8'h06, 8'h01, 8'h04, 8'h07, 8'h00, 8'h03,
                   8'h05};
        // Hand-derived codewords for the corner messages.
        exp_lo[0] = 8'h00; exp_hi[0] = 8'h00;
        exp_lo[1] = 8'hFF; exp_hi[1] = 8'hFF;
        exp_lo[2] = 8'h0F; exp_hi[2] = 8'h00;
        exp_lo[3] = 8'h17; exp_hi[3] = 8'h81;
        exp_lo[4] = 8'h00; exp_hi[4] = 8'h00;
        for (int i = 5; i < 15; i++) begin
            cw = enc(src_lo[i], src_hi[i]);
            exp_lo[i] = cw[7:0];
            exp_hi[i] = cw[15:8];
        end
    endtask

    task automatic load_src();
        for (int i = 0; i < 15; i++) begin
            load_byte(8'(2 * i), src_lo[i]);
            load_byte(8'(2 * i + 1), src_hi[i]);
        end
    endtask

    task automatic clear_dst();
        for (int i = 0; i < 30; i++) begin
            load_byte(8'(30 + i), 8'hAA);
        end
    endtask

    // Messages below n_ok must be encoded; the rest still hold 0xAA.
    task automatic check_mem(input string tag, input int n_ok);
        logic [7:0] el, eh;
        for (int i = 0; i < 15; i++) begin
            el = (i < n_ok) ? exp_lo[i] : 8'hAA;
            eh = (i < n_ok) ? exp_hi[i] : 8'hAA;
            n_tests++;
            if (mem[30 + 2 * i] !== el) begin
                n_fail++;
                $display("FAIL %s cw%0d_lo got %h want %h",
                         tag, i, mem[30 + 2 * i], el);
            end
            n_tests++;
            if (mem[31 + 2 * i] !== eh) begin
                n_fail++;
                $display("FAIL %s cw%0d_hi got %h want %h",
                         tag, i, mem[31 + 2 * i], eh);
            end
            n_tests++;
            if (mem[2 * i] !== src_lo[i] || mem[2 * i + 1] !== src_hi[i]) begin
                n_fail++;
                $display("FAIL %s src%0d got %h%h want %h%h", tag, i,
                         mem[2 * i + 1], mem[2 * i], src_hi[i], src_lo[i]);
            end
        end
    endtask

    // Pulses start, optionally re-pulses it at edge `repulse`, and checks
    // latency, done drop and write-strobe count.
    task automatic run_once(input string tag, input int repulse);
        int cyc;
        int w0;
        w0    = wr_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_drop got %b want 0", tag, done);
        end
        while (done !== 1'b1 && cyc < 200) begin
            start = (cyc + 1 == repulse);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        n_tests++;
        if (cyc != 60 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s latency got %0d want 60", tag, cyc);
        end
        n_tests++;
        if (wr_cnt - w0 != 30) begin
            n_fail++;
            $display("FAIL %s wr_count got %0d want 30", tag, wr_cnt - w0);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (done !== 1'b0 || mem_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ctl got done=%b we=%b want 0 0",
                     done, mem_wr_en);
        end
        n_tests++;
        if (mem_addr !== 8'd0 || mem_wr_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset bus got a=%h d=%h want 00 00",
                     mem_addr, mem_wr_data);
        end
    endtask

    task automatic test_idle_hold();
        int w0;
        w0 = wr_cnt;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b0 || wr_cnt != w0 || mem_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL idle_hold got done=%b writes=%0d a=%h want 0 0 00",
                     done, wr_cnt - w0, mem_addr);
        end
    endtask

    task automatic test_vectors();
        run_once("vectors", 0);
        check_mem("vectors", 15);
    endtask

    task automatic test_done_hold();
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b1 || mem_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold got done=%b we=%b want 1 0",
                     done, mem_wr_en);
        end
    endtask

    task automatic test_restart_from_done();
        clear_dst();
        run_once("rerun", 0);
        check_mem("rerun", 15);
    endtask

    task automatic test_start_ignored();
        clear_dst();
        run_once("ignored", 10);
        check_mem("ignored", 15);
    endtask

    task automatic test_reset_mid_run();
        int w0;
        clear_dst();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (26) @(posedge clk);
        #1;
        n_tests++;
        if (mem_wr_en !== 1'b1 || mem_addr !== 8'd42) begin
            n_fail++;
            $display("FAIL mid_run got we=%b a=%h want 1 2a",
                     mem_wr_en, mem_addr);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (done !== 1'b0 || mem_wr_en !== 1'b0 ||
            mem_addr !== 8'd0 || mem_wr_data !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset got done=%b we=%b a=%h d=%h want 0 0 00 00",
                     done, mem_wr_en, mem_addr, mem_wr_data);
        end
        w0 = wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_tests++;
        if (wr_cnt != w0) begin
            n_fail++;
            $display("FAIL reset_writes got %0d want 0", wr_cnt - w0);
        end
        check_mem("aborted", 6);
        test_idle_hold();
        run_once("after_reset", 0);
        check_mem("after_reset", 15);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        #1;
        test_reset();
        setup_tables();
        load_src();
        clear_dst();
        reset = 1'b0;
        test_idle_hold();
        test_vectors();
        test_done_hold();
        test_restart_from_done();
        test_start_ignored();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_enc_engine.md
HAMMING_ENC_ENGINE -- requirements
Module: hamming_enc_engine

Interface
REQ-001 Parameter NUM_MSG, default 15: number of 11-bit messages encoded per run.
REQ-002 Parameter SRC_BASE, default 0: data-memory byte address of message 0 low byte.
REQ-003 Parameter DST_BASE, default 30: data-memory byte address of codeword 0 low byte.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 start  input  1  run request, sampled on rising clk.
REQ-008 done  output  1  high while the engine is in DONE.
REQ-009 mem_addr  output  8  data-memory byte address.
REQ-010 mem_rd_data  input  8  combinational (same-cycle) read data for mem_addr.
REQ-011 mem_wr_en  output  1  write strobe; memory writes mem_wr_data at mem_addr on rising clk.
REQ-012 mem_wr_data  output  8  write data.

Function
REQ-013 Message i occupies bytes SRC_BASE+2i (d[8:1]) and SRC_BASE+2i+1 (bits [2:0] = d[11:9]; bits [7:3] ignored).
REQ-014 Parity: p8 = ^d[11:5]; p4 = ^d[11:8] ^ ^d[4:2]; p2 = d11^d10^d7^d6^d4^d3^d1; p1 = d11^d9^d7^d5^d4^d2^d1; p0 = ^d[11:1]^p8^p4^p2^p1.
REQ-015 Codeword cw[15:0] = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
REQ-016 cw[7:0] is written to DST_BASE+2i, cw[15:8] to DST_BASE+2i+1.
REQ-017 States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE; 4-bit message index i.
REQ-018 IDLE or DONE with start=1 at a clk edge -> RD_LO, i=0; otherwise hold.
REQ-019 RD_LO: mem_addr=SRC_BASE+2i; mem_rd_data latched as low byte; -> RD_HI.
REQ-020 RD_HI: mem_addr=SRC_BASE+2i+1; mem_rd_data[2:0] latched as high bits; -> WR_LO.
REQ-021 WR_LO: mem_wr_en=1, mem_addr=DST_BASE+2i, mem_wr_data=cw[7:0]; -> WR_HI.
REQ-022 WR_HI: mem_wr_en=1, mem_addr=DST_BASE+2i+1, mem_wr_data=cw[15:8]; if i==NUM_MSG-1 -> DONE, else i++ and -> RD_LO.
REQ-023 mem_wr_en SHALL be 0 in every state other than WR_LO/WR_HI.
REQ-024 Latency: done rises exactly 4*NUM_MSG cycles after the edge that sampled start (60 for default).
REQ-025 done stays high in DONE until start is sampled; it drops the cycle after that edge.
REQ-026 start while in RD_LO..WR_HI SHALL be ignored; the run continues unchanged.
REQ-027 Address arithmetic is 8-bit modulo 256; no range checking.
REQ-028 Parity is computed combinationally from latched bytes; no extra pipeline cycle.

Reset
REQ-029 reset=1 forces state=IDLE, i=0, latched bytes=0, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0 immediately, independent of clk.
REQ-030 reset asserted mid-run aborts the run: no further writes; bytes already written remain; a new start restarts from i=0.

Verification
REQ-031 Message 0x000 (bytes 00,00) -> codeword bytes lo=0x00, hi=0x00.
REQ-032 Message 0x7FF (bytes FF,07) -> lo=0xFF, hi=0xFF; message 0x001 (01,00) -> lo=0x0F, hi=0x00.
REQ-033 Message 0x400 (bytes 00,04) -> lo=0x17, hi=0x81; hi input byte 0xF8 with lo 0x00 -> lo=0x00, hi=0x00 (bits [7:3] ignored).
REQ-034 15 random messages, pulse start for 1 cycle -> done high exactly 60 cycles later; bytes 30..59 match REQ-015; bytes 0..29 unchanged; exactly 30 write strobes.
REQ-035 start re-pulsed at cycle 10 of a run -> no restart, done still at cycle 60; start in DONE -> second full run with identical results.
REQ-036 reset asserted at cycle 25 -> done=0 and mem_wr_en=0 immediately, state IDLE; subsequent start -> full correct run.
